// File: rtl/bitsel_pkg.sv
// Shared types for the iterative select (N-th set bit) engine.
// Holds the FSM state encoding and the index-width helper used by every bitsel file.
package bitsel_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_IDX_W = $clog2(DEF_WIDTH);

   // Bits needed to name one bit position of a WIDTH-wide word.
   function automatic int idx_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/bitselpenc.sv
// Lowest-set-bit isolator plus one-hot-to-index encoder; purely combinational.
// An all-zero mask yields low_o=0 and idx_o=0; callers test the mask separately.
module bitselpenc
   import bitsel_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0]         mask_i,
   output logic [WIDTH-1:0]         low_o,
   output logic [$clog2(WIDTH)-1:0] idx_o
);

   localparam int IW = idx_w(WIDTH);

   // Two's-complement trick: x & -x keeps only the lowest set bit.
   assign low_o = mask_i & (~mask_i + WIDTH'(1));

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (low_o[i]) idx_o = idx_o | IW'(i);
      end
   end

endmodule

// File: rtl/bitsel_iter.sv
// Iterative select: index of the (N+1)-th set bit, one bit cleared per SCAN cycle; Done at t+2+min(N,popcount).
// Start is only taken in IDLE (ignored while Busy); Flush aborts silently. Macro BITSEL_REV_EN enables MSB-first scan via RevA.
module bitsel_iter
   import bitsel_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         a_i,
   input  logic [WIDTH-1:0]         rev_a_i,
   input  logic [$clog2(WIDTH)-1:0] n_i,
   input  logic                     w64_i,
   input  logic                     rev_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     found_o,
   output logic [WIDTH-1:0]         sel_result_o
);

   localparam int IW = idx_w(WIDTH);
   localparam int RW = IW + 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic [RW-1:0]    res_q, res_d;
   logic             found_q, found_d;
   logic             lim64_q, lim64_d;

   logic             rev_sel;
   logic             wide_lim;
   logic [WIDTH-1:0] cap_mask;
   logic [WIDTH-1:0] low_bit;
   logic [IW-1:0]    low_idx;
   logic [RW-1:0]    limit;

`ifdef BITSEL_REV_EN
   assign rev_sel = rev_i;
`else
   logic unused_rev;
   assign rev_sel    = 1'b0;
   assign unused_rev = ^{rev_i, rev_a_i};
`endif

   if (WIDTH == 64) begin : g_w64
      logic [31:0] lo_word;
      // Word mode scans only the low 32 bits of the operand; reversed, that is RevA's upper half.
      assign lo_word  = rev_sel ? rev_a_i[WIDTH-1:32] : a_i[31:0];
      assign cap_mask = w64_i ? {32'b0, lo_word} : (rev_sel ? rev_a_i : a_i);
      assign wide_lim = ~w64_i;
   end else begin : g_w32
      logic unused_w64;
      assign cap_mask   = rev_sel ? rev_a_i : a_i;
      assign wide_lim   = 1'b0;
      assign unused_w64 = w64_i;
   end

   bitselpenc #(.WIDTH(WIDTH)) u_penc (
      .mask_i (mask_q),
      .low_o  (low_bit),
      .idx_o  (low_idx)
   );

   assign limit = lim64_q ? RW'(WIDTH) : RW'(32);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      found_d = found_q;
      lim64_d = lim64_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SCAN;
               mask_d  = cap_mask;
               cnt_d   = n_i;
               lim64_d = wide_lim;
            end
         end
         SCAN: begin
            if (mask_q == '0) begin
               res_d   = limit;
               found_d = 1'b0;
               state_d = DONE;
            end else if (cnt_q == '0) begin
               res_d   = {1'b0, low_idx};
               found_d = 1'b1;
               state_d = DONE;
            end else begin
               mask_d = mask_q & ~low_bit;
               cnt_d  = cnt_q - IW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort wins over capture and termination; published results stay untouched.
      if (flush_i) begin
         state_d = IDLE;
         mask_d  = mask_q;
         cnt_d   = cnt_q;
         res_d   = res_q;
         found_d = found_q;
         lim64_d = lim64_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         found_q <= 1'b0;
         lim64_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         found_q <= found_d;
         lim64_q <= lim64_d;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign found_o      = found_q;
   assign sel_result_o = {{(WIDTH-RW){1'b0}}, res_q};

endmodule

// File: tb/tb_bitsel_iter.sv
// Bench for bitsel_iter: a WIDTH=32 and a WIDTH=64 instance share stimulus, one selected per operation.
module tb_bitsel_iter;

`ifdef BITSEL_REV_EN
   localparam bit REV_EN = 1'b1;
`else
   localparam bit REV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [63:0] a = '0;
   logic [5:0]  n = '0;
   logic        w64 = 1'b0;
   logic        rev = 1'b0;
   logic        sel64 = 1'b0;

   logic [31:0] rev32;
   logic [63:0] rev64;
   logic        busy32, done32, found32, busy64, done64, found64;
   logic [31:0] res32;
   logic [63:0] res64;
   logic        o_busy, o_done, o_found;
   logic [63:0] o_sel;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 32; i++) rev32[i] = a[31-i];
      for (int i = 0; i < 64; i++) rev64[i] = a[63-i];
   end

   bitsel_iter #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start_i(start & ~sel64), .flush_i(flush),
      .a_i(a[31:0]), .rev_a_i(rev32), .n_i(n[4:0]), .w64_i(w64), .rev_i(rev),
      .busy_o(busy32), .done_o(done32), .found_o(found32), .sel_result_o(res32)
   );

   bitsel_iter #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(reset), .start_i(start & sel64), .flush_i(flush),
      .a_i(a), .rev_a_i(rev64), .n_i(n), .w64_i(w64), .rev_i(rev),
      .busy_o(busy64), .done_o(done64), .found_o(found64), .sel_result_o(res64)
   );

   assign o_busy  = sel64 ? busy64  : busy32;
   assign o_done  = sel64 ? done64  : done32;
   assign o_found = sel64 ? found64 : found32;
   assign o_sel   = sel64 ? res64   : {32'b0, res32};

   // Reference: walk the scanned word bit by bit, counting ones until the (n+1)-th.
   function automatic void model(input bit wide, input logic [63:0] av, input int nv,
                                 input bit w, input bit r,
                                 output int res, output bit fnd, output int lat);
      int span, seen;
      bit b;
      span = (wide && !w) ? 64 : 32;
      seen = 0;
      res  = span;
      fnd  = 1'b0;
      for (int i = 0; i < span; i++) begin
         b = (REV_EN && r) ? av[span-1-i] : av[i];
         if (b) begin
            if (seen == nv && !fnd) begin
               res = i;
               fnd = 1'b1;
            end
            seen++;
         end
      end
      lat = 2 + ((nv < seen) ? nv : seen);
   endfunction

   // Runs one operation from an IDLE cycle; returns observations and leaves the DUT in IDLE.
   task automatic do_op(input bit wide, input logic [63:0] av, input int nv, input bit w, input bit r,
                        output int lat, output logic [63:0] res, output logic fnd,
                        output int busy_drop, output logic idle_busy);
      sel64 = wide; a = av; n = 6'(nv); w64 = w; rev = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = {$urandom, $urandom}; n = 6'($urandom); w64 = 1'($urandom); rev = 1'($urandom);
      lat = 1; busy_drop = 0;
      while (!o_done && lat < 200) begin
         if (!o_busy) busy_drop++;
         @(posedge clk); #1;
         lat++;
      end
      if (!o_done) lat = -1;
      res = o_sel; fnd = o_found;
      @(posedge clk); #1;
      idle_busy = o_busy;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; flush = 1'b1; a = 64'hFF;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (o_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b want=0", o_busy); end
      n_tests++; if (o_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b want=0", o_done); end
      n_tests++; if (o_found !== 1'b0)   begin n_fail++; $display("FAIL reset_found got=%b want=0", o_found); end
      n_tests++; if (o_sel !== 64'd0)    begin n_fail++; $display("FAIL reset_sel got=%0d want=0", o_sel); end
      sel64 = 1'b1; #1;
      n_tests++; if (o_sel !== 64'd0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_w64 sel=%0d busy=%b want 0/0", o_sel, o_busy); end
      reset = 1'b0; start = 1'b0; flush = 1'b0; sel64 = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          wide;
      logic [63:0] av;
      int          nv;
      bit          w;
      bit          r;
      int          er;
      bit          ef;
      int          el;
   } vec_t;

   task automatic test_directed();
      vec_t vecs[9];
      int lat, bd;
      logic [63:0] res;
      logic fnd, ib;
      vecs[0] = '{1'b0, 64'h0000_00F0, 2, 1'b0, 1'b0, 6, 1'b1, 4};
      vecs[1] = '{1'b0, 64'h0, 0, 1'b0, 1'b0, 32, 1'b0, 2};
      vecs[2] = '{1'b0, 64'h0000_0003, 5, 1'b0, 1'b0, 32, 1'b0, 4};
      vecs[3] = '{1'b0, 64'h8000_0001, 0, 1'b0, 1'b1, 0, 1'b1, 2};
      vecs[4] = '{1'b0, 64'h8000_0001, 1, 1'b0, 1'b0, 31, 1'b1, 3};
      vecs[5] = '{1'b1, 64'hFFFF_FFFF_0000_0001, 1, 1'b1, 1'b0, 32, 1'b0, 3};
      vecs[6] = '{1'b1, 64'hFFFF_FFFF_0000_0001, 1, 1'b0, 1'b0, 32, 1'b1, 3};
      vecs[7] = '{1'b1, 64'h0, 0, 1'b0, 1'b0, 64, 1'b0, 2};
      vecs[8] = '{1'b0, 64'hFFFF_FFFF, 31, 1'b0, 1'b0, 31, 1'b1, 33};
      foreach (vecs[k]) begin
         do_op(vecs[k].wide, vecs[k].av, vecs[k].nv, vecs[k].w, vecs[k].r, lat, res, fnd, bd, ib);
         n_tests++; if (lat !== vecs[k].el) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, vecs[k].el); end
         n_tests++; if (res !== 64'(vecs[k].er)) begin n_fail++; $display("FAIL dir%0d_result got=%0d want=%0d", k, res, vecs[k].er); end
         n_tests++; if (fnd !== vecs[k].ef) begin n_fail++; $display("FAIL dir%0d_found got=%b want=%b", k, fnd, vecs[k].ef); end
         n_tests++; if (bd != 0 || ib !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy drops=%0d idle_busy=%b want 0/0", k, bd, ib); end
      end
   endtask

   task automatic test_random();
      int lat, bd, er, el, nv, mode;
      bit wide, w, r, ef;
      logic [63:0] av, res;
      logic fnd, ib;
      for (int k = 0; k < 60; k++) begin
         wide = 1'($urandom);
         w    = 1'($urandom);
         r    = 1'($urandom);
         mode = $urandom_range(0, 3);
         case (mode)
            0:       av = {$urandom, $urandom};
            1:       av = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            2:       av = 64'h0;
            default: av = ~(64'h1 << $urandom_range(0, 63));
         endcase
         nv = $urandom_range(0, wide ? 63 : 31);
         model(wide, av, nv, w, r, er, ef, el);
         do_op(wide, av, nv, w, r, lat, res, fnd, bd, ib);
         n_tests++; if (lat !== el) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d want=%0d a=%h n=%0d", k, lat, el, av, nv); end
         n_tests++; if (res !== 64'(er)) begin n_fail++; $display("FAIL rnd%0d_result got=%0d want=%0d a=%h n=%0d", k, res, er, av, nv); end
         n_tests++; if (fnd !== ef) begin n_fail++; $display("FAIL rnd%0d_found got=%b want=%b", k, fnd, ef); end
         n_tests++; if (bd != 0) begin n_fail++; $display("FAIL rnd%0d_busy drops=%0d want=0", k, bd); end
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      sel64 = 1'b0; a = 64'hFFFF_FFFF; n = 6'd10; w64 = 1'b0; rev = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 64'h0; n = 6'd0;
      lat = 1;
      while (!o_done && lat < 200) begin
         if (lat == 6) start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      n_tests++; if (lat !== 12) begin n_fail++; $display("FAIL busy_start_latency got=%0d want=12", lat); end
      n_tests++; if (o_sel !== 64'd10 || o_found !== 1'b1) begin n_fail++; $display("FAIL busy_start_result got=%0d/%b want=10/1", o_sel, o_found); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      int lat, bd, saw_done;
      logic [63:0] res;
      logic fnd, ib;
      // Previous operation left SelResult=10, Found=1.
      sel64 = 1'b0; a = 64'hFFFF_FFFF; n = 6'd20; start = 1'b1; saw_done = 0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (o_done) saw_done++;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      if (o_done) saw_done++;
      n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b want=0", o_busy); end
      n_tests++; if (saw_done != 0) begin n_fail++; $display("FAIL flush_done pulses=%0d want=0", saw_done); end
      n_tests++; if (o_sel !== 64'd10 || o_found !== 1'b1) begin n_fail++; $display("FAIL flush_hold got=%0d/%b want=10/1", o_sel, o_found); end
      do_op(1'b0, 64'h0000_00F0, 2, 1'b0, 1'b0, lat, res, fnd, bd, ib);
      n_tests++; if (lat !== 4 || bd != 0) begin n_fail++; $display("FAIL flush_restart latency=%0d drops=%0d want 4/0", lat, bd); end
      n_tests++; if (res !== 64'd6 || fnd !== 1'b1) begin n_fail++; $display("FAIL flush_restart_result got=%0d/%b want=6/1", res, fnd); end
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_over_start busy=%b want=0", o_busy); end
   endtask

   task automatic test_back_to_back();
      int lat, bd, er, el;
      bit ef;
      logic [63:0] av, res;
      logic fnd, ib;
      for (int k = 0; k < 4; k++) begin
         av = {$urandom, $urandom} | 64'h1;
         model(1'b1, av, k, 1'b0, 1'b0, er, ef, el);
         do_op(1'b1, av, k, 1'b0, 1'b0, lat, res, fnd, bd, ib);
         n_tests++; if (lat !== el || res !== 64'(er) || fnd !== ef) begin n_fail++; $display("FAIL b2b%0d lat=%0d res=%0d fnd=%b want %0d/%0d/%b", k, lat, res, fnd, el, er, ef); end
      end
   endtask

   task automatic test_reset_mid();
      int saw_done;
      sel64 = 1'b0; a = 64'hFFFF_FFFF; n = 6'd20; start = 1'b1; saw_done = 0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1; flush = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; flush = 1'b0; start = 1'b0;
      n_tests++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_state busy=%b done=%b want 0/0", o_busy, o_done); end
      n_tests++; if (o_sel !== 64'd0 || o_found !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs got=%0d/%b want=0/0", o_sel, o_found); end
      for (int c = 0; c < 25; c++) begin
         if (o_done || o_busy) saw_done++;
         @(posedge clk); #1;
      end
      n_tests++; if (saw_done != 0) begin n_fail++; $display("FAIL rstmid_no_done activity=%0d want=0", saw_done); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
